hack_arbiter4: RTL and testbench

Four-way round-robin arbiter that produces the 2-bit select pair (s0, s1) consumed directly by hack_decoder2, so that the decoder's one-hot output enables exactly one of four Hack bus clients. The arbiter holds a grant until the owner signals done or an optional hold timeout expires. It then rotates priority so the next requester after the previous owner wins. It sits immediately upstream of hack_decoder2 in the shared-bus path.

---
 rtl/hack_arbiter_pkg.sv | 27 ++
 rtl/hack_rr_pick4.sv | 36 +++
 rtl/hack_arbiter4.sv | 133 +++++++++++++
 tb/tb_hack_arbiter4.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_arbiter_pkg.sv
// Shared types, constants and index helpers for the four-way Hack bus arbiter.
package hack_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    // Arbiter control states.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Rotate a client index by an offset, wrapping mod NUM_REQ.
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] off);
        return IDX_W'(idx + off);
    endfunction

    // One-hot expansion of a client index.
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hack_rr_pick4.sv
// Combinational round-robin pick: first unmasked requester scanning from ptr.
//   req_i   : request vector, bit k is client k
//   ptr_i   : index scanned first
//   mask_i  : clients excluded from this pick
//   found_o : some eligible requester exists
//   idx_o   : winning index (ptr_i when nothing found)
module hack_rr_pick4
    import hack_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic [NUM_REQ-1:0] mask_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   cand;

    assign elig = req_i & ~mask_i;

    // Scan ptr, ptr+1, ... and keep the first eligible hit.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = rot_idx(ptr_i, IDX_W'(i));
            if (!found_o && elig[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/hack_arbiter4.sv
// Four-way round-robin arbiter driving the hack_decoder2 select pair.
// Holds a grant until done or an optional hold timeout, then rotates
// priority to the requester after the previous owner.
//   clk, reset : clock and synchronous active-high reset
//   req        : request vector, req[k] is client k
//   done       : owner releases the bus (ignored while idle)
//   s0, s1     : registered select, owner = 2*s1 + s0
//   valid      : a grant is active
//   gnt        : one-hot grant, zero while idle
//   timeout    : one-cycle pulse when the grant was revoked by timeout
module hack_arbiter4
    import hack_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               s0,
    output logic               s1,
    output logic               valid,
    output logic [NUM_REQ-1:0] gnt,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic             TO_EN   = (TIMEOUT != 0);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               to_q, to_d;

    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               to_hit;

    // While granted, the pick is the release pick: start after the owner and skip it.
    assign pick_ptr  = (state_q == GRANT) ? rot_idx(idx_q, IDX_W'(1)) : ptr_q;
    assign pick_mask = (state_q == GRANT) ? onehot4(idx_q) : '0;
    assign to_hit    = TO_EN && (cnt_q == TO_LAST);

    hack_rr_pick4 u_pick (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .mask_i  (pick_mask),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            gnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        gnt_d   = gnt_q;
        to_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    gnt_d   = onehot4(pick_idx);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (done || to_hit) begin
                    ptr_d = rot_idx(idx_q, IDX_W'(1));
                    // done wins over a coincident timeout: no pulse.
                    to_d  = !done;
                    if (pick_found) begin
                        idx_d = pick_idx;
                        gnt_d = onehot4(pick_idx);
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s0      = idx_q[0];
    assign s1      = idx_q[1];
    assign valid   = valid_q;
    assign gnt     = gnt_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_hack_arbiter4.sv
// Bench for hack_arbiter4: two instances (no timeout, TIMEOUT=3) on shared
// stimulus, each checked every cycle against a behavioural owner/ptr model.
module tb_hack_arbiter4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;

    logic       s0    [2];
    logic       s1    [2];
    logic       valid [2];
    logic [3:0] gnt   [2];
    logic       tout  [2];

    int checks = 0;
    int errors = 0;
    bit run_cmp = 0;

    localparam int TOV [2] = '{0, 3};

    hack_arbiter4 #(.TIMEOUT(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .s0(s0[0]), .s1(s1[0]), .valid(valid[0]), .gnt(gnt[0]), .timeout(tout[0])
    );

    hack_arbiter4 #(.TIMEOUT(3), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .s0(s0[1]), .s1(s1[1]), .valid(valid[1]), .gnt(gnt[1]), .timeout(tout[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: owner (-1 = none), rotating pointer, cycles held so far.
    int m_owner [2] = '{-1, -1};
    int m_ptr   [2] = '{0, 0};
    int m_held  [2] = '{0, 0};
    bit m_to    [2] = '{0, 0};

    function automatic int first_req(input logic [3:0] r, input int start, input int skip);
        for (int i = 0; i < 4; i++) begin
            int k = (start + i) % 4;
            if (r[k] && k != skip) return k;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_owner[d] = -1; m_ptr[d] = 0; m_held[d] = 0; m_to[d] = 0;
            end else if (m_owner[d] < 0) begin
                m_to[d]    = 0;
                m_owner[d] = first_req(req, m_ptr[d], -1);
                m_held[d]  = 1;
            end else if (done || (TOV[d] != 0 && m_held[d] == TOV[d])) begin
                m_to[d]    = !done;
                m_ptr[d]   = (m_owner[d] + 1) % 4;
                m_owner[d] = first_req(req, m_ptr[d], m_owner[d]);
                m_held[d]  = 1;
            end else begin
                m_to[d]   = 0;
                m_held[d] = m_held[d] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            for (int d = 0; d < 2; d++) begin
                logic [3:0] eg;
                logic [1:0] es;
                logic [1:0] sel;
                logic [3:0] dec;
                eg  = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0000;
                es  = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'b00;
                sel = {s1[d], s0[d]};
                dec = 4'b0001 << sel;
                chk($sformatf("dut%0d valid", d), 32'(valid[d]), 32'(m_owner[d] >= 0));
                chk($sformatf("dut%0d gnt", d), 32'(gnt[d]), 32'(eg));
                chk($sformatf("dut%0d sel", d), 32'(sel), 32'(es));
                chk($sformatf("dut%0d timeout", d), 32'(tout[d]), 32'(m_to[d]));
                if (valid[d] === 1'b1)
                    chk($sformatf("dut%0d decoder", d), 32'(dec), 32'(gnt[d]));
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic dn, input logic rs);
        req   = r;
        done  = dn;
        reset = rs;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectation for one instance.
    task automatic lit(input int d, input string nm, input logic v, input logic [3:0] g,
                       input logic [1:0] s, input logic t);
        chk({nm, $sformatf(" dut%0d valid", d)}, 32'(valid[d]), 32'(v));
        chk({nm, $sformatf(" dut%0d gnt", d)}, 32'(gnt[d]), 32'(g));
        chk({nm, $sformatf(" dut%0d sel", d)}, 32'({s1[d], s0[d]}), 32'(s));
        chk({nm, $sformatf(" dut%0d timeout", d)}, 32'(tout[d]), 32'(t));
    endtask

    initial begin
        logic [3:0] r;
        logic       dn;
        logic       rs;
        req = '0; done = 1'b0; reset = 1'b1;

        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        run_cmp = 1;
        lit(0, "reset", 1'b0, 4'b0000, 2'd0, 1'b0);
        lit(1, "reset", 1'b0, 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            lit(0, "idle", 1'b0, 4'b0000, 2'd0, 1'b0);
        end

        step(4'b0100, 1'b0, 1'b0);
        lit(0, "grant2", 1'b1, 4'b0100, 2'd2, 1'b0);
        lit(1, "grant2", 1'b1, 4'b0100, 2'd2, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        lit(0, "hold", 1'b1, 4'b0100, 2'd2, 1'b0);

        // Full request with done every grant: 0,1,2,3,0 back to back.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        lit(0, "rr0", 1'b1, 4'b0001, 2'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(4'b1111, 1'b1, 1'b0);
            lit(0, "rr", 1'b1, 4'(1 << (k % 4)), 2'(k % 4), 1'b0);
        end

        // req=1011: 0 -> 1 -> 3 -> 0, pointer wraps to 0 after the third release.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1011, 1'b0, 1'b0);
        lit(0, "skip a", 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b1011, 1'b1, 1'b0);
        lit(0, "skip b", 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b1011, 1'b1, 1'b0);
        lit(0, "skip c", 1'b1, 4'b1000, 2'd3, 1'b0);
        step(4'b1011, 1'b1, 1'b0);
        lit(0, "skip d", 1'b1, 4'b0001, 2'd0, 1'b0);

        // Timeout of 3 cycles on owner 2, then done coincident with timeout.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        lit(1, "to held1", 1'b1, 4'b0100, 2'd2, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        lit(1, "to held2", 1'b1, 4'b0100, 2'd2, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        lit(1, "to held3", 1'b1, 4'b0100, 2'd2, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        lit(1, "to fire", 1'b1, 4'b0001, 2'd0, 1'b1);
        lit(0, "no to", 1'b1, 4'b0100, 2'd2, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        lit(1, "to pulse end", 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        step(4'b0101, 1'b1, 1'b0);
        lit(1, "done+to", 1'b1, 4'b0100, 2'd2, 1'b0);
        lit(0, "done", 1'b1, 4'b0001, 2'd0, 1'b0);

        // Reset mid-grant, then pointer restarts at 0.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0);
        lit(0, "own3", 1'b1, 4'b1000, 2'd3, 1'b0);
        step(4'b1000, 1'b0, 1'b1);
        lit(0, "mid rst", 1'b0, 4'b0000, 2'd0, 1'b0);
        lit(1, "mid rst", 1'b0, 4'b0000, 2'd0, 1'b0);
        step(4'b1001, 1'b0, 1'b0);
        lit(0, "post rst", 1'b1, 4'b0001, 2'd0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            dn = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 96) == 0);
            step(r, dn, rs);
        end

        @(negedge clk);
        run_cmp = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
